// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the instruction-memory loader.
// A byte moves on every rising edge where byte_valid and byte_ready are both 1;
// the source holds byte_data stable while byte_valid waits, and ready never depends on valid.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [15:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a COUNT / 2N data bytes / CSUM image into instruction memory and
// keeps the core in reset until an image with a matching checksum has landed.
module imem_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  typedef struct packed {
    logic ready;
    logic busy;
    logic hold;
    logic done;
    logic err;
  } flags_t;

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  // Status outputs are a pure function of the state being entered, so every
  // transition loads them together with the state register.
  function automatic flags_t flags(input state_t s);
    flags_t f;
    f.ready = (s == S_COUNT) || (s == S_HI) || (s == S_LO) || (s == S_CSUM);
    f.busy  = f.ready || (s == S_WRITE);
    f.hold  = (s != S_DONE);
    f.done  = (s == S_DONE);
    f.err   = (s == S_ERR);
    return f;
  endfunction

  state_t            state;
  flags_t            fl;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic [7:0]        nwords;
  logic [7:0]        wcnt;
  logic [7:0]        hi;
  logic [7:0]        sum;
  logic [TW-1:0]     tcnt;
  logic              accept;
  logic              timed_out;

  assign accept    = bus.byte_valid && fl.ready;
  assign timed_out = (TIMEOUT != 0) && fl.ready && !accept && (tcnt == TLAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      fl     <= flags(S_IDLE);
      we     <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      nwords <= '0;
      wcnt   <= '0;
      hi     <= '0;
      sum    <= '0;
      tcnt   <= '0;
    end else begin
      we <= 1'b0;
      if (fl.ready) begin
        tcnt <= accept ? '0 : tcnt + TW'(1);
      end
      if (timed_out) begin
        state <= S_ERR;
        fl    <= flags(S_ERR);
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
              state <= S_COUNT;
              fl    <= flags(S_COUNT);
              addr  <= '0;
              sum   <= '0;
              wcnt  <= '0;
              tcnt  <= '0;
            end
          end
          S_COUNT: begin
            if (accept) begin
              if (bus.byte_data == 8'd0) begin
                state <= S_ERR;
                fl    <= flags(S_ERR);
              end else begin
                nwords <= bus.byte_data;
                state  <= S_HI;
                fl     <= flags(S_HI);
              end
            end
          end
          S_HI: begin
            if (accept) begin
              hi    <= bus.byte_data;
              sum   <= sum + bus.byte_data;
              state <= S_LO;
              fl    <= flags(S_LO);
            end
          end
          S_LO: begin
            if (accept) begin
              wdata <= {hi, bus.byte_data};
              sum   <= sum + bus.byte_data;
              we    <= 1'b1;
              state <= S_WRITE;
              fl    <= flags(S_WRITE);
            end
          end
          S_WRITE: begin
            addr <= addr + ADDR_W'(1);
            wcnt <= wcnt + 8'd1;
            if ((wcnt + 8'd1) == nwords) begin
              state <= S_CSUM;
              fl    <= flags(S_CSUM);
            end else begin
              state <= S_HI;
              fl    <= flags(S_HI);
            end
          end
          S_CSUM: begin
            if (accept) begin
              state <= (bus.byte_data == sum) ? S_DONE : S_ERR;
              fl    <= flags((bus.byte_data == sum) ? S_DONE : S_ERR);
            end
          end
          default: begin
            state <= S_IDLE;
            fl    <= flags(S_IDLE);
          end
        endcase
      end
    end
  end

  assign bus.byte_ready = fl.ready;
  assign bus.imem_we    = we;
  assign bus.imem_waddr = addr;
  assign bus.imem_wdata = wdata;
  assign cpu_hold       = fl.hold;
  assign busy           = fl.busy;
  assign done           = fl.done;
  assign err            = fl.err;
  assign state_dbg      = state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader: a queue of expected writes,
// an image model with plain checksum arithmetic, and a memory capturing writes.
module tb_imem_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] state_dbg;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int          tests = 0;
  int          fails = 0;
  int          busy_cycles = 0;
  logic [23:0] exp_q[$];
  logic [15:0] img[256];
  logic [15:0] tb_mem[256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every imem write must match the head of exp_q
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (bus.imem_we === 1'b1) begin
      check("we_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      check("ready_in_write", {31'd0, bus.byte_ready}, 32'd0);
      if (exp_q.size() != 0) check("write", {8'd0, bus.imem_waddr, bus.imem_wdata}, {8'd0, exp_q.pop_front()});
      tb_mem[bus.imem_waddr] = bus.imem_wdata;
    end
  end

  // drivers
  task automatic pulse_start();
    busy_cycles = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n;
    bus.byte_valid = 1'b0;
    repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.byte_ready) break;
      n++;
      if (n > 100) begin
        check("byte_ready_wait", {31'd0, bus.byte_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  // Loads img[0..n-1]; csum_override < 0 sends the correct checksum.
  task automatic run_load(input int n, input int csum_override, input int max_gap);
    logic [7:0] sum;
    logic [7:0] csum;
    logic       good;
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), img[i]});
      sum = 8'(sum + img[i][15:8] + img[i][7:0]);
    end
    csum = (csum_override < 0) ? sum : 8'(csum_override);
    good = (csum == sum);
    pulse_start();
    send_byte(8'(n), max_gap);
    for (int i = 0; i < n; i++) begin
      send_byte(img[i][15:8], max_gap);
      send_byte(img[i][7:0], max_gap);
    end
    send_byte(csum, max_gap);
    @(negedge clk);
    check("load_done", {31'd0, done}, {31'd0, good});
    check("load_err", {31'd0, err}, {31'd0, !good});
    check("load_hold", {31'd0, cpu_hold}, {31'd0, !good});
    check("load_busy", {31'd0, busy}, 32'd0);
    check("writes_left", exp_q.size(), 32'd0);
    if (max_gap == 0) check("load_cycles", busy_cycles, 32'(2 + 3 * n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    check({tag, "_we"}, {31'd0, bus.imem_we}, 32'd0);
    check({tag, "_waddr"}, {24'd0, bus.imem_waddr}, 32'd0);
    check({tag, "_wdata"}, {16'd0, bus.imem_wdata}, 32'd0);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // two-word image at full rate, checksum from the mod-256 sum rule
    img[0] = 16'h1234;
    img[1] = 16'hABCD;
    run_load(2, -1, 0);

    // same image, wrong checksum: writes still happen, load fails
    run_load(2, 8'h15, 0);

    // zero word count fails right after the COUNT byte
    pulse_start();
    send_byte(8'h00, 0);
    @(negedge clk);
    check("zero_count_err", {31'd0, err}, 32'd1);
    check("zero_count_busy", {31'd0, busy}, 32'd0);
    check("zero_count_done", {31'd0, done}, 32'd0);

    // stall after the hi byte until the idle timeout fires
    pulse_start();
    send_byte(8'd2, 0);
    send_byte(8'h55, 0);
    repeat (16) @(negedge clk);
    check("stall15_err", {31'd0, err}, 32'd0);
    check("stall15_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("stall16_err", {31'd0, err}, 32'd1);
    check("stall16_hold", {31'd0, cpu_hold}, 32'd1);
    run_load(2, -1, 0);

    // full-size random image with random source gaps
    for (int i = 0; i < 255; i++) img[i] = 16'($urandom);
    run_load(255, -1, 3);
    for (int i = 0; i < 255; i++) check("mem_255", {16'd0, tb_mem[i]}, {16'd0, img[i]});

    // reset right after the third word write
    for (int i = 0; i < 8; i++) img[i] = 16'($urandom);
    pulse_start();
    send_byte(8'd8, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({8'(i), img[i]});
      send_byte(img[i][15:8], 0);
      send_byte(img[i][7:0], 0);
    end
    @(negedge clk);
    check("third_we", {31'd0, bus.imem_we}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check("midreset_writes_left", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_load(8, -1, 1);
    for (int i = 0; i < 8; i++) check("mem_8", {16'd0, tb_mem[i]}, {16'd0, img[i]});

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
